// File: rtl/bt_update_queue.sv
// bt_update_queue: BTB update producer.
// Collects resolved branches from the branch unit and emits BTB insert
// requests on the packed 67-bit update bus. Candidates are taken branches
// or jumps that missed in the BTB. They are held in a DEPTH-entry FIFO and
// drained one per cycle while IN_outReady is high.
// Optional feature: define BTU_DEDUP_EN to drop candidates whose source PC
// is already queued, sitting valid in the output register, or among the
// last HIST emitted source PCs.
module bt_update_queue #(
    parameter int DEPTH = 4,
    parameter int HIST  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IN_brValid,
    input  logic [30:0] IN_brSrc,
    input  logic [30:0] IN_brDst,
    input  logic        IN_brTaken,
    input  logic        IN_brIsJump,
    input  logic        IN_brCompr,
    input  logic        IN_brBtbHit,
    input  logic        IN_clear,
    input  logic        IN_outReady,
    output logic [66:0] OUT_btUpdate,
    output logic        OUT_full,
    output logic [15:0] OUT_dropCount
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || HIST < 1) begin : g_bad_param
        $error("bt_update_queue: DEPTH must be a power of two >= 2 and HIST >= 1");
    end

    // FIFO control state
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             full_q;
    logic [15:0]      drop_cnt;

    // FIFO payload storage (not reset; qualified by count)
    logic [30:0] fifo_src   [DEPTH];
    logic [30:0] fifo_dst   [DEPTH];
    logic        fifo_jump  [DEPTH];
    logic        fifo_compr [DEPTH];

    // Output register
    logic        out_vld;
    logic        out_compr;
    logic        out_jump;
    logic [30:0] out_dst;
    logic [30:0] out_src;

    // Per-cycle decisions
    logic is_cand;
    logic dup;
    logic accept;
    logic pop_raw;
    logic do_pop;
    logic do_push;
    logic do_drop;

    assign is_cand = IN_brValid && !IN_brBtbHit && (IN_brTaken || IN_brIsJump);
    assign pop_raw = IN_outReady && (count != '0);
    // Clear wins over both push and pop in its cycle.
    assign do_pop  = pop_raw && !IN_clear;
    assign accept  = is_cand && !dup && !IN_clear;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign do_push = accept && ((count != DEPTH_C) || pop_raw);
    assign do_drop = accept && (count == DEPTH_C) && !pop_raw;

`ifdef BTU_DEDUP_EN
    logic [30:0]      hist_src [HIST];
    logic [HIST-1:0]  hist_vld;
    logic [PTR_W-1:0] dist;

    // Duplicate detection against live FIFO entries (including the head being
    // popped this cycle), the valid output register and the emit history.
    always_comb begin
        dup  = 1'b0;
        dist = '0;
        for (int i = 0; i < DEPTH; i++) begin
            dist = PTR_W'(i) - rd_ptr;
            if (({1'b0, dist} < count) && (fifo_src[i] == IN_brSrc)) begin
                dup = 1'b1;
            end
        end
        if (out_vld && (out_src == IN_brSrc)) begin
            dup = 1'b1;
        end
        for (int h = 0; h < HIST; h++) begin
            if (hist_vld[h] && (hist_src[h] == IN_brSrc)) begin
                dup = 1'b1;
            end
        end
    end

    // History valid bits: shift in a set bit on every pop, cleared by rst/clear.
    always_ff @(posedge clk) begin
        if (rst || IN_clear) begin
            hist_vld <= '0;
        end else if (do_pop) begin
            for (int h = HIST - 1; h > 0; h--) begin
                hist_vld[h] <= hist_vld[h-1];
            end
            hist_vld[0] <= 1'b1;
        end
    end

    // History source PCs: newest popped src at index 0, oldest falls off.
    always_ff @(posedge clk) begin
        if (do_pop) begin
            for (int h = HIST - 1; h > 0; h--) begin
                hist_src[h] <= hist_src[h-1];
            end
            hist_src[0] <= fifo_src[rd_ptr];
        end
    end
`else
    assign dup = 1'b0;
`endif

    // Next occupancy from the push/pop decision of this cycle.
    always_comb begin
        count_nxt = count;
        if (IN_clear) begin
            count_nxt = '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count_nxt = count + 1'b1;
                2'b01:   count_nxt = count - 1'b1;
                default: count_nxt = count;
            endcase
        end
    end

    // Pointers, occupancy, full flag and saturating overflow counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full_q   <= 1'b0;
            drop_cnt <= '0;
        end else begin
            count  <= count_nxt;
            full_q <= (count_nxt == DEPTH_C);
            if (IN_clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
            if (do_drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    // FIFO payload write at the tail.
    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_src[wr_ptr]   <= IN_brSrc;
            fifo_dst[wr_ptr]   <= IN_brDst;
            fifo_jump[wr_ptr]  <= IN_brIsJump;
            fifo_compr[wr_ptr] <= IN_brCompr;
        end
    end

    // Output register: valid for one cycle per pop, payload holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld   <= 1'b0;
            out_compr <= 1'b0;
            out_jump  <= 1'b0;
            out_dst   <= '0;
            out_src   <= '0;
        end else if (IN_clear) begin
            out_vld <= 1'b0;
        end else begin
            out_vld <= do_pop;
            if (do_pop) begin
                out_compr <= fifo_compr[rd_ptr];
                out_jump  <= fifo_jump[rd_ptr];
                out_dst   <= fifo_dst[rd_ptr];
                out_src   <= fifo_src[rd_ptr];
            end
        end
    end

    assign OUT_btUpdate  = {out_src, 1'b0, out_dst, 1'b0, out_jump, out_compr, out_vld};
    assign OUT_full      = full_q;
    assign OUT_dropCount = drop_cnt;

endmodule

// File: tb/tb_bt_update_queue.sv
// tb_bt_update_queue: directed bench for bt_update_queue with a scoreboard.
// Expected updates are queued when a candidate is driven and compared when
// the DUT shows a valid update. Honours BTU_DEDUP_EN for the dedup step.
module tb_bt_update_queue;

`ifdef BTU_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    typedef struct packed {
        logic [30:0] src;
        logic [30:0] dst;
        logic        jump;
        logic        compr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        IN_brValid;
    logic [30:0] IN_brSrc;
    logic [30:0] IN_brDst;
    logic        IN_brTaken;
    logic        IN_brIsJump;
    logic        IN_brCompr;
    logic        IN_brBtbHit;
    logic        IN_clear;
    logic        IN_outReady;
    logic [66:0] OUT_btUpdate;
    logic        OUT_full;
    logic [15:0] OUT_dropCount;

    int   checks = 0;
    int   errors = 0;
    int   emits  = 0;
    int   e0;
    exp_t exp_q[$];
    exp_t mon_e;

    bt_update_queue #(.DEPTH(4), .HIST(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .IN_brValid   (IN_brValid),
        .IN_brSrc     (IN_brSrc),
        .IN_brDst     (IN_brDst),
        .IN_brTaken   (IN_brTaken),
        .IN_brIsJump  (IN_brIsJump),
        .IN_brCompr   (IN_brCompr),
        .IN_brBtbHit  (IN_brBtbHit),
        .IN_clear     (IN_clear),
        .IN_outReady  (IN_outReady),
        .OUT_btUpdate (OUT_btUpdate),
        .OUT_full     (OUT_full),
        .OUT_dropCount(OUT_dropCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one branch for one cycle; queue the expected update if it should emit.
    task automatic present(input logic [30:0] s, input logic [30:0] d, input logic j,
                           input logic c, input logic t, input logic h, input bit expect_emit);
        exp_t e;
        if (expect_emit) begin
            e.src   = s;
            e.dst   = d;
            e.jump  = j;
            e.compr = c;
            exp_q.push_back(e);
        end
        IN_brValid  = 1'b1;
        IN_brSrc    = s;
        IN_brDst    = d;
        IN_brIsJump = j;
        IN_brCompr  = c;
        IN_brTaken  = t;
        IN_brBtbHit = h;
        tick();
        IN_brValid  = 1'b0;
        IN_brTaken  = 1'b0;
        IN_brIsJump = 1'b0;
        IN_brBtbHit = 1'b0;
    endtask

    // Scoreboard: every valid update must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && OUT_btUpdate[0] === 1'b1) begin
            emits++;
            if (exp_q.size() == 0) begin
                chk("unexpected_emit", OUT_btUpdate, 67'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("emit", OUT_btUpdate,
                    {mon_e.src, 1'b0, mon_e.dst, 1'b0, mon_e.jump, mon_e.compr, 1'b1});
            end
        end
    end

    initial begin
        rst = 1'b1;
        IN_brValid = 1'b0;  IN_brSrc = '0;    IN_brDst = '0;
        IN_brTaken = 1'b0;  IN_brIsJump = 1'b0; IN_brCompr = 1'b0;
        IN_brBtbHit = 1'b0; IN_clear = 1'b0;  IN_outReady = 1'b0;
        repeat (3) tick();
        chk("reset_bus", OUT_btUpdate, 67'd0);
        chk_int("reset_full", int'(OUT_full), 0);
        chk_int("reset_drop", int'(OUT_dropCount), 0);
        rst = 1'b0;
        tick();

        // Basic emit with two-cycle latency
        IN_outReady = 1'b1;
        tick();
        present(31'h100, 31'h200, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        chk("basic_emit", OUT_btUpdate, {31'h100, 1'b0, 31'h200, 1'b0, 1'b1, 1'b1, 1'b1});
        tick();
        chk_int("basic_valid_gone", int'(OUT_btUpdate[0]), 0);

        // Filtering: BTB hit, and not-taken non-jump
        e0 = emits;
        present(31'h300, 31'h301, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        present(31'h302, 31'h303, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (10) tick();
        chk_int("filter_no_emit", emits - e0, 0);
        chk_int("filter_drop", int'(OUT_dropCount), 0);

        // Overflow with ready low
        IN_outReady = 1'b0;
        for (int i = 0; i < 7; i++) begin
            present(31'h10 + 31'(i), 31'h50 + 31'(i), 1'b0, 1'b0, 1'b1, 1'b0, i < 4);
            if (i == 2) chk_int("ovf_not_full_3", int'(OUT_full), 0);
            if (i == 3) chk_int("ovf_full_4", int'(OUT_full), 1);
        end
        chk_int("ovf_drop", int'(OUT_dropCount), 3);
        e0 = emits;
        IN_outReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_int("ovf_back_to_back", int'(OUT_btUpdate[0]), 1);
        end
        tick();
        chk_int("ovf_drain_done", int'(OUT_btUpdate[0]), 0);
        chk_int("ovf_emit_count", emits - e0, 4);
        chk_int("ovf_full_after", int'(OUT_full), 0);

        // Full FIFO with simultaneous push and pop
        e0 = emits;
        IN_outReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            present(31'h20 + 31'(i), 31'h60 + 31'(i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        chk_int("pp_full", int'(OUT_full), 1);
        IN_outReady = 1'b1;
        for (int i = 4; i < 12; i++) begin
            present(31'h20 + 31'(i), 31'h60 + 31'(i), 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        end
        chk_int("pp_still_full", int'(OUT_full), 1);
        repeat (8) tick();
        chk_int("pp_drop_const", int'(OUT_dropCount), 3);
        chk_int("pp_emit_count", emits - e0, 12);
        chk_int("pp_full_after", int'(OUT_full), 0);

        // Clear with a same-cycle candidate and ready
        e0 = emits;
        IN_outReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            present(31'h30 + 31'(i), 31'h70 + 31'(i), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        IN_clear = 1'b1;
        IN_outReady = 1'b1;
        present(31'h33, 31'h73, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        IN_clear = 1'b0;
        chk_int("clear_valid", int'(OUT_btUpdate[0]), 0);
        chk_int("clear_full", int'(OUT_full), 0);
        repeat (10) tick();
        chk_int("clear_no_emit", emits - e0, 0);
        chk_int("clear_drop_kept", int'(OUT_dropCount), 3);

        // Duplicate source PCs: queued, duplicate while queued, again after emit
        e0 = emits;
        IN_outReady = 1'b0;
        present(31'h40, 31'h41, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        present(31'h40, 31'h41, 1'b1, 1'b0, 1'b1, 1'b0, !DEDUP);
        IN_outReady = 1'b1;
        repeat (4) tick();
        present(31'h40, 31'h41, 1'b1, 1'b0, 1'b1, 1'b0, !DEDUP);
        repeat (6) tick();
        chk_int("dedup_emit_count", emits - e0, DEDUP ? 1 : 3);
        chk_int("dedup_drop", int'(OUT_dropCount), 3);

        // Reset in the middle of operation
        e0 = emits;
        IN_outReady = 1'b0;
        present(31'h60, 31'h80, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        present(31'h61, 31'h81, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        chk("midrst_bus", OUT_btUpdate, 67'd0);
        chk_int("midrst_full", int'(OUT_full), 0);
        chk_int("midrst_drop", int'(OUT_dropCount), 0);
        rst = 1'b0;
        IN_outReady = 1'b1;
        repeat (6) tick();
        chk_int("midrst_no_emit", emits - e0, 0);

        chk_int("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
